// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART frame scheduler
package uart_pkg;

    localparam int NCH_DEFAULT     = 4;
    localparam int TIMEOUT_DEFAULT = 1024;
    localparam int WORD_W          = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_FREE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting after the last grant
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);

    logic [IW-1:0] cand;
    logic          found;

    // Scan channels last+1, last+2, ... wrapping; the last grantee has lowest priority.
    // Wrap relies on NCH being a power of two (index arithmetic overflows naturally).
    always_comb begin
        gnt   = '0;
        idx   = last;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = last + IW'(i);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - per-channel word holding slots with round-robin issue to a UART framer
module uart_frame_scheduler
    import uart_pkg::*;
#(
    parameter int NCH     = NCH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_valid,
    input  logic [WORD_W*NCH-1:0] req_data,
    input  logic [NCH-1:0]        req_test,
    input  logic                  enable,
    input  logic                  frm_busy,
    input  logic                  err_clr,
    output logic [WORD_W-1:0]     tx_float,
    output logic                  tx_valid,
    output logic                  tx_test,
    output logic [1:0]            grant_ch,
    output logic [NCH-1:0]        pending,
    output logic [NCH-1:0]        overrun,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT);

    state_t             state;
    state_t             state_next;

    logic [WORD_W-1:0]  slot_data [NCH];
    logic [NCH-1:0]     slot_test;
    logic [NCH-1:0]     pending_q;
    logic [NCH-1:0]     overrun_q;
    logic               timeout_q;

    logic [WORD_W-1:0]  tx_float_q;
    logic               tx_test_q;
    logic [1:0]         last_grant;
    logic [CW-1:0]      cnt;

    logic [NCH-1:0]     arb_gnt;
    logic [1:0]         arb_idx;
    logic               issuing;
    logic               timeout_hit;
    logic [NCH-1:0]     issue_mask;
    logic [NCH-1:0]     ovr_set;

    rr_arbiter #(
        .NCH (NCH),
        .IW  (2)
    ) u_arb (
        .req  (pending_q),
        .last (last_grant),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // Next-state logic; enable is only consulted in IDLE so a frame in flight always completes.
    always_comb begin
        state_next  = state;
        issuing     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !frm_busy && (|pending_q))
                    state_next = ISSUE;
            end
            ISSUE: begin
                issuing    = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (frm_busy) begin
                    state_next = WAIT_FREE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_FREE: begin
                if (!frm_busy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A word arriving on a channel that is being issued this cycle replaces the slot
    // without counting as an overrun: the old word is leaving through tx_float.
    always_comb begin
        issue_mask = issuing ? arb_gnt : '0;
        ovr_set    = req_valid & pending_q & ~issue_mask;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Counts frm_busy-low cycles spent in WAIT_BUSY; cleared everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == WAIT_BUSY && !frm_busy)
            cnt <= cnt + CW'(1);
        else
            cnt <= '0;
    end

    // Holding slots and pending flags; a new word always sets pending, even during its own issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                slot_data[c] <= '0;
            slot_test <= '0;
            pending_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (req_valid[c]) begin
                    slot_data[c] <= req_data[WORD_W*c +: WORD_W];
                    slot_test[c] <= req_test[c];
                    pending_q[c] <= 1'b1;
                end else if (issue_mask[c]) begin
                    pending_q[c] <= 1'b0;
                end
            end
        end
    end

    // Sticky error flags; a setting event in the same cycle beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ovr_set[c])
                    overrun_q[c] <= 1'b1;
                else if (err_clr)
                    overrun_q[c] <= 1'b0;
            end
            if (timeout_hit)
                timeout_q <= 1'b1;
            else if (err_clr)
                timeout_q <= 1'b0;
        end
    end

    // Latch the issued word and grant so they stay on the outputs until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_float_q <= '0;
            tx_test_q  <= 1'b0;
            last_grant <= 2'(NCH - 1);
        end else if (issuing) begin
            tx_float_q <= slot_data[arb_idx];
            tx_test_q  <= slot_test[arb_idx];
            last_grant <= arb_idx;
        end
    end

    // During ISSUE the selected slot is shown directly, giving the two-cycle request-to-launch latency.
    always_comb begin
        tx_valid    = issuing;
        tx_float    = issuing ? slot_data[arb_idx] : tx_float_q;
        tx_test     = issuing ? slot_test[arb_idx] : tx_test_q;
        grant_ch    = issuing ? arb_idx : last_grant;
        pending     = pending_q;
        overrun     = overrun_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - directed self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [127:0]  req_data;
    logic [3:0]    req_test;
    logic          enable;
    logic          frm_busy;
    logic          err_clr;
    logic [31:0]   tx_float;
    logic          tx_valid;
    logic          tx_test;
    logic [1:0]    grant_ch;
    logic [3:0]    pending;
    logic [3:0]    overrun;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    uart_frame_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_test    (req_test),
        .enable      (enable),
        .frm_busy    (frm_busy),
        .err_clr     (err_clr),
        .tx_float    (tx_float),
        .tx_valid    (tx_valid),
        .tx_test     (tx_test),
        .grant_ch    (grant_ch),
        .pending     (pending),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input int ch, input logic [31:0] d, input logic t);
        req_valid[ch]         = 1'b1;
        req_data[32*ch +: 32] = d;
        req_test[ch]          = t;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_test  = '0;
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'b0, tx_valid}, 32'd1);
    endtask

    // Framer model: busy for n+1 cycles starting now; nothing may issue meanwhile.
    task automatic frame(input int n);
        frm_busy = 1'b1;
        for (int k = 0; k <= n; k++) begin
            step();
            chk("busy_no_issue", {31'b0, tx_valid}, 32'd0);
        end
        frm_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_test = '0;
        enable = 1'b1; frm_busy = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_float", tx_float, 32'd0);
        chk("rst_grant", {30'b0, grant_ch}, 32'd3);
        chk("rst_pending", {28'b0, pending}, 32'd0);
        chk("rst_overrun", {28'b0, overrun}, 32'd0);
        chk("rst_timeout", {31'b0, timeout_err}, 32'd0);
        rst = 1'b0;

        // single word on channel 2, two-cycle latency
        pulse(2, 32'hDEADBEEF, 1'b0);
        step(); clear_req();
        chk("t1_pending", {28'b0, pending}, 32'h4);
        chk("t1_not_yet", {31'b0, tx_valid}, 32'd0);
        step();
        chk("t1_tx_valid", {31'b0, tx_valid}, 32'd1);
        chk("t1_tx_float", tx_float, 32'hDEADBEEF);
        chk("t1_grant", {30'b0, grant_ch}, 32'd2);
        step();
        chk("t1_one_pulse", {31'b0, tx_valid}, 32'd0);
        chk("t1_hold", tx_float, 32'hDEADBEEF);
        chk("t1_pending_clr", {28'b0, pending}, 32'd0);
        frame(1);

        // all four channels at once after reset: order 0,1,2,3
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 4; c++) pulse(c, 32'h100 + c, (c == 3));
        step(); clear_req();
        for (int c = 0; c < 4; c++) begin
            wait_tx($sformatf("t2_issue%0d", c), 10);
            chk($sformatf("t2_data%0d", c), tx_float, 32'h100 + c);
            chk($sformatf("t2_grant%0d", c), {30'b0, grant_ch}, c);
            chk($sformatf("t2_test%0d", c), {31'b0, tx_test}, (c == 3) ? 32'd1 : 32'd0);
            frame(2);
        end

        // overrun on channel 1 while framer busy
        frm_busy = 1'b1;
        pulse(1, 32'h1, 1'b0); step();
        pulse(1, 32'h2, 1'b0); step(); clear_req();
        chk("t3_overrun", {28'b0, overrun}, 32'h2);
        chk("t3_pending", {28'b0, pending}, 32'h2);
        chk("t3_blocked", {31'b0, tx_valid}, 32'd0);
        frm_busy = 1'b0;
        wait_tx("t3_issue", 10);
        chk("t3_data", tx_float, 32'h2);
        chk("t3_grant", {30'b0, grant_ch}, 32'd1);
        frame(1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t3_clr", {28'b0, overrun}, 32'd0);
        frm_busy = 1'b1;
        pulse(1, 32'h3, 1'b0); step();
        pulse(1, 32'h4, 1'b0); err_clr = 1'b1; step(); clear_req(); err_clr = 1'b0;
        chk("t3_set_wins", {28'b0, overrun}, 32'h2);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t3_clr2", {28'b0, overrun}, 32'd0);
        frm_busy = 1'b0;
        wait_tx("t3_issue2", 10);
        chk("t3_data2", tx_float, 32'h4);
        frame(1);

        // timeout: frm_busy never rises
        pulse(2, 32'h55, 1'b0); step(); clear_req();
        wait_tx("t4_issue", 10);
        chk("t4_data", tx_float, 32'h55);
        chk("t4_grant", {30'b0, grant_ch}, 32'd2);
        pulse(3, 32'h66, 1'b1); step(); clear_req();
        repeat (1023) step();
        chk("t4_no_timeout_yet", {31'b0, timeout_err}, 32'd0);
        step();
        chk("t4_timeout", {31'b0, timeout_err}, 32'd1);
        chk("t4_idle_no_tx", {31'b0, tx_valid}, 32'd0);
        step();
        chk("t4_next_issue", {31'b0, tx_valid}, 32'd1);
        chk("t4_next_data", tx_float, 32'h66);
        chk("t4_next_test", {31'b0, tx_test}, 32'd1);
        chk("t4_next_grant", {30'b0, grant_ch}, 32'd3);
        frame(1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t4_clr", {31'b0, timeout_err}, 32'd0);

        // new word on channel 0 during its own ISSUE cycle
        pulse(0, 32'h77, 1'b0); step(); clear_req(); step();
        chk("t5_issue", {31'b0, tx_valid}, 32'd1);
        chk("t5_data", tx_float, 32'h77);
        chk("t5_grant", {30'b0, grant_ch}, 32'd0);
        pulse(0, 32'h88, 1'b0); step(); clear_req();
        chk("t5_pending", {28'b0, pending}, 32'h1);
        chk("t5_no_overrun", {28'b0, overrun}, 32'd0);
        chk("t5_hold", tx_float, 32'h77);
        frame(1);
        wait_tx("t5_issue2", 10);
        chk("t5_data2", tx_float, 32'h88);
        chk("t5_grant2", {30'b0, grant_ch}, 32'd0);
        frame(1);

        // enable low blocks new issues
        enable = 1'b0;
        pulse(1, 32'h5A, 1'b0); step(); clear_req();
        repeat (3) step();
        chk("t6_disabled", {31'b0, tx_valid}, 32'd0);
        chk("t6_pending", {28'b0, pending}, 32'h2);
        enable = 1'b1;
        wait_tx("t6_issue", 10);
        chk("t6_data", tx_float, 32'h5A);
        frame(1);

        // reset during WAIT_FREE
        pulse(2, 32'h99, 1'b0); step(); clear_req();
        wait_tx("t7_issue", 10);
        chk("t7_data", tx_float, 32'h99);
        frm_busy = 1'b1;
        step(); step();
        pulse(0, 32'hAB, 1'b0); step(); clear_req();
        chk("t7_pending", {28'b0, pending}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t7_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("t7_rst_tx_float", tx_float, 32'd0);
        chk("t7_rst_grant", {30'b0, grant_ch}, 32'd3);
        chk("t7_rst_pending", {28'b0, pending}, 32'd0);
        chk("t7_rst_test", {31'b0, tx_test}, 32'd0);
        step();
        rst = 1'b0; frm_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t7_no_issue", {31'b0, tx_valid}, 32'd0);
        end
        pulse(1, 32'hC1, 1'b0); step(); clear_req(); step();
        chk("t7_new_issue", {31'b0, tx_valid}, 32'd1);
        chk("t7_new_data", tx_float, 32'hC1);
        chk("t7_new_grant", {30'b0, grant_ch}, 32'd1);
        frame(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_scheduler.md
UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of requester channels (fixed to 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles to wait for frm_busy to rise after an issue.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NCH  per-channel one-cycle pulse offering a word.
REQ-006 SHALL have port req_data  input  32*NCH  channel c word on bits [32c+31:32c].
REQ-007 SHALL have port req_test  input  NCH  per-channel test-PID select, sampled with req_valid.
REQ-008 SHALL have port enable  input  1  when low, no new issue starts; capture continues.
REQ-009 SHALL have port frm_busy  input  1  downstream framer busy, high for the whole frame.
REQ-010 SHALL have port err_clr  input  1  one-cycle pulse clearing the sticky flags.
REQ-011 SHALL have port tx_float  output  32  word presented to the framer.
REQ-012 SHALL have port tx_valid  output  1  one-cycle launch pulse to the framer.
REQ-013 SHALL have port tx_test  output  1  test select accompanying tx_float.
REQ-014 SHALL have port grant_ch  output  2  channel of the current or last issue.
REQ-015 SHALL have port pending  output  NCH  per-channel holding-register-full flags.
REQ-016 SHALL have port overrun  output  NCH  sticky flag: an unissued word was overwritten.
REQ-017 SHALL have port timeout_err  output  1  sticky flag: frm_busy did not rise within TIMEOUT cycles.

Function
REQ-018 SHALL hold one 33-bit slot per channel (data plus test) and set pending[c] on req_valid[c].
REQ-019 SHALL overwrite the slot and set overrun[c] when req_valid[c] arrives while pending[c] is set and the slot is not being issued in that cycle.
REQ-020 SHALL, when req_valid[c] coincides with the issue of channel c, issue the old word, store the new word, keep pending[c]=1, and leave overrun[c] unchanged.
REQ-021 SHALL implement the FSM states IDLE, ISSUE, WAIT_BUSY and WAIT_FREE.
REQ-022 SHALL transition from IDLE to ISSUE when enable=1, frm_busy=0 and any pending bit is set.
REQ-023 SHALL, in ISSUE, pick a channel round-robin starting at the channel after the last grant, copy its slot to tx_float/tx_test, clear its pending bit, update grant_ch, assert tx_valid for exactly one cycle, and go to WAIT_BUSY.
REQ-024 SHALL go from WAIT_BUSY to WAIT_FREE when frm_busy=1.
REQ-025 SHALL go from WAIT_BUSY to IDLE and set timeout_err when TIMEOUT cycles elapse with frm_busy=0.
REQ-026 SHALL go from WAIT_FREE to IDLE when frm_busy=0.
REQ-027 SHALL give a minimum issue-to-issue spacing of 4 cycles and a latency of 2 cycles from req_valid (scheduler idle, framer free) to tx_valid.
REQ-028 SHALL hold tx_float and tx_test stable from tx_valid until the next issue.
REQ-029 SHALL have err_clr clear overrun and timeout_err, and SHALL let a flag-setting event in the same cycle win over err_clr.
REQ-030 SHALL let a deassertion of enable take effect only in IDLE, never aborting a frame in progress.
REQ-031 SHALL map any illegal state encoding to IDLE.

Reset
REQ-032 SHALL, on reset, force state=IDLE, all slots and pending=0, tx_float=0, tx_valid=0, tx_test=0, grant_ch=NCH-1 (first grant goes to channel 0), overrun=0, timeout_err=0, and the timeout counter to 0.
REQ-033 SHALL drop tx_valid and discard all pending words immediately on reset asserted mid-frame.

Structure
REQ-034 SHALL place NCH, the state encoding and the TIMEOUT default in a shared package, uart_pkg.
REQ-035 SHALL instantiate one sub-module, rr_arbiter (NCH-wide request vector, last-grant input, one-hot grant plus index output, combinational).

Verification
REQ-036 SHALL cover: a single req_valid[2] with 0xDEADBEEF and framer idle -> tx_valid 2 cycles later, tx_float=0xDEADBEEF, grant_ch=2.
REQ-037 SHALL cover: all four channels pulsed in the same cycle after reset -> issues in order 0,1,2,3, each issue only after frm_busy falls.
REQ-038 SHALL cover: channel 1 pulsed twice (0x1, then 0x2) while the framer is busy -> only 0x2 is issued, overrun=0001-bit-1 (0b0010); err_clr -> overrun=0.
REQ-039 SHALL cover: frm_busy held at 0 after an issue -> IDLE after 1024 cycles, timeout_err=1, next pending issue proceeds.
REQ-040 SHALL cover: req_valid[0] in the ISSUE cycle of channel 0 -> old word issued, pending[0]=1, overrun[0]=0.
REQ-041 SHALL cover: rst asserted in WAIT_FREE -> all outputs at reset values in the same cycle; no issue until a new req_valid.
